// File: rtl/ioctl_rom_writer.sv
// ioctl_rom_writer
// Packs the HPS ROM download byte stream into 16-bit SDRAM words and writes
// them over a toggle request/acknowledge handshake. Even bytes wait in a
// one-entry pending register so they can be paired with the following odd
// byte. Unpaired bytes are flushed as single-lane writes.
//
// Ports
//   CLK_32M, reset_n      : clock, asynchronous active-low reset
//   ioctl_download/wr/index/addr/dout : HPS download byte stream
//   ioctl_wait            : backpressure, high while an SDRAM write is in flight
//   sdr_addr/din/wrl/wrh  : word address, data and byte-lane enables
//   sdr_req / sdr_ack     : request toggle out, acknowledge toggle in
//   done                  : one-cycle pulse once a download has fully drained
//   err_overrun           : sticky, a qualified byte arrived while busy
//   bytes_written         : bytes committed to SDRAM in the current download
module ioctl_rom_writer #(
    parameter logic [7:0]  INDEX = 8'd0,
    parameter logic [23:0] BASE  = 24'h000000
) (
    input  logic        CLK_32M,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [23:0] sdr_addr,
    output logic [15:0] sdr_din,
    output logic        sdr_wrl,
    output logic        sdr_wrh,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic        done,
    output logic        err_overrun,
    output logic [24:0] bytes_written
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_BUSY2 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        dl_q, dl_d;
    logic        pend_valid_q, pend_valid_d;
    logic [23:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        end_pend_q, end_pend_d;
    logic        done_wait_q, done_wait_d;
    logic [23:0] qd_addr_q, qd_addr_d;
    logic [15:0] qd_din_q, qd_din_d;
    logic        qd_wrl_q, qd_wrl_d;
    logic        qd_wrh_q, qd_wrh_d;
    logic        sdr_req_q, sdr_req_d;
    logic [23:0] sdr_addr_q, sdr_addr_d;
    logic [15:0] sdr_din_q, sdr_din_d;
    logic        sdr_wrl_q, sdr_wrl_d;
    logic        sdr_wrh_q, sdr_wrh_d;
    logic        wait_q, wait_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [24:0] bytes_q, bytes_d;

    // Request to launch this cycle, merged into the output registers below.
    logic        iss_en;
    logic [23:0] iss_addr;
    logic [15:0] iss_din;
    logic        iss_wrl;
    logic        iss_wrh;

    logic        wr_qual;
    logic        dl_rise;
    logic        dl_fall;
    logic        ack;
    logic [23:0] byte_waddr;
    logic [23:0] pend_sdr_addr;
    logic [23:0] new_sdr_addr;
    logic [24:0] cur_lanes;

    assign wr_qual       = ioctl_wr && ioctl_download && (ioctl_index == INDEX);
    assign dl_rise       = ioctl_download && !dl_q;
    assign dl_fall       = !ioctl_download && dl_q;
    assign ack           = (sdr_ack == sdr_req_q);
    assign byte_waddr    = ioctl_addr[24:1];
    assign pend_sdr_addr = pend_addr_q + BASE;
    assign new_sdr_addr  = byte_waddr + BASE;
    assign cur_lanes     = {24'd0, sdr_wrl_q} + {24'd0, sdr_wrh_q};

    always_comb begin
        state_d      = state_q;
        dl_d         = ioctl_download;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        end_pend_d   = end_pend_q;
        done_wait_d  = done_wait_q;
        qd_addr_d    = qd_addr_q;
        qd_din_d     = qd_din_q;
        qd_wrl_d     = qd_wrl_q;
        qd_wrh_d     = qd_wrh_q;
        sdr_req_d    = sdr_req_q;
        sdr_addr_d   = sdr_addr_q;
        sdr_din_d    = sdr_din_q;
        sdr_wrl_d    = sdr_wrl_q;
        sdr_wrh_d    = sdr_wrh_q;
        done_d       = 1'b0;
        iss_en       = 1'b0;
        iss_addr     = '0;
        iss_din      = '0;
        iss_wrl      = 1'b0;
        iss_wrh      = 1'b0;

        // A new download restarts the counter and the error flag; an ack in
        // the same cycle still contributes its lanes to the fresh count.
        bytes_d = dl_rise ? '0 : bytes_q;
        err_d   = dl_rise ? 1'b0 : err_q;
        if (wr_qual && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_SYNC: begin
                // Align the request toggle with whatever the controller holds
                // so the first comparison does not look like an open request.
                sdr_req_d = sdr_ack;
                state_d   = ST_IDLE;
                if (dl_fall) begin
                    end_pend_d = 1'b1;
                end
            end

            ST_IDLE: begin
                if (end_pend_q || dl_fall) begin
                    end_pend_d = 1'b0;
                    if (wr_qual) begin
                        err_d = 1'b1;
                    end
                    if (pend_valid_q) begin
                        iss_en       = 1'b1;
                        iss_addr     = pend_sdr_addr;
                        iss_din      = {8'h00, pend_data_q};
                        iss_wrl      = 1'b1;
                        pend_valid_d = 1'b0;
                        done_wait_d  = 1'b1;
                        state_d      = ST_BUSY;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (wr_qual) begin
                    if (!ioctl_addr[0]) begin
                        // Even byte: push out any older orphan, then park it.
                        if (pend_valid_q) begin
                            iss_en   = 1'b1;
                            iss_addr = pend_sdr_addr;
                            iss_din  = {8'h00, pend_data_q};
                            iss_wrl  = 1'b1;
                            state_d  = ST_BUSY;
                        end
                        pend_valid_d = 1'b1;
                        pend_addr_d  = byte_waddr;
                        pend_data_d  = ioctl_dout;
                    end else if (pend_valid_q && (pend_addr_q == byte_waddr)) begin
                        iss_en       = 1'b1;
                        iss_addr     = new_sdr_addr;
                        iss_din      = {ioctl_dout, pend_data_q};
                        iss_wrl      = 1'b1;
                        iss_wrh      = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = ST_BUSY;
                    end else if (pend_valid_q) begin
                        // Flush the orphan first; the odd byte waits in the
                        // queue registers until that write is acked.
                        iss_en       = 1'b1;
                        iss_addr     = pend_sdr_addr;
                        iss_din      = {8'h00, pend_data_q};
                        iss_wrl      = 1'b1;
                        qd_addr_d    = new_sdr_addr;
                        qd_din_d     = {ioctl_dout, 8'h00};
                        qd_wrl_d     = 1'b0;
                        qd_wrh_d     = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = ST_BUSY2;
                    end else begin
                        iss_en   = 1'b1;
                        iss_addr = new_sdr_addr;
                        iss_din  = {ioctl_dout, 8'h00};
                        iss_wrh  = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                if (dl_fall) begin
                    end_pend_d = 1'b1;
                end
                if (ack) begin
                    bytes_d = bytes_d + cur_lanes;
                    state_d = ST_IDLE;
                    if (done_wait_q) begin
                        done_d      = 1'b1;
                        done_wait_d = 1'b0;
                    end
                end
            end

            ST_BUSY2: begin
                if (dl_fall) begin
                    end_pend_d = 1'b1;
                end
                if (ack) begin
                    bytes_d  = bytes_d + cur_lanes;
                    iss_en   = 1'b1;
                    iss_addr = qd_addr_q;
                    iss_din  = qd_din_q;
                    iss_wrl  = qd_wrl_q;
                    iss_wrh  = qd_wrh_q;
                    state_d  = ST_BUSY;
                end
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase

        if (iss_en) begin
            sdr_req_d  = ~sdr_req_q;
            sdr_addr_d = iss_addr;
            sdr_din_d  = iss_din;
            sdr_wrl_d  = iss_wrl;
            sdr_wrh_d  = iss_wrh;
        end

        wait_d = (state_d == ST_BUSY) || (state_d == ST_BUSY2);
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SYNC;
            dl_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            end_pend_q   <= 1'b0;
            done_wait_q  <= 1'b0;
            qd_addr_q    <= '0;
            qd_din_q     <= '0;
            qd_wrl_q     <= 1'b0;
            qd_wrh_q     <= 1'b0;
            sdr_req_q    <= 1'b0;
            sdr_addr_q   <= '0;
            sdr_din_q    <= '0;
            sdr_wrl_q    <= 1'b0;
            sdr_wrh_q    <= 1'b0;
            wait_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            bytes_q      <= '0;
        end else begin
            state_q      <= state_d;
            dl_q         <= dl_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            end_pend_q   <= end_pend_d;
            done_wait_q  <= done_wait_d;
            qd_addr_q    <= qd_addr_d;
            qd_din_q     <= qd_din_d;
            qd_wrl_q     <= qd_wrl_d;
            qd_wrh_q     <= qd_wrh_d;
            sdr_req_q    <= sdr_req_d;
            sdr_addr_q   <= sdr_addr_d;
            sdr_din_q    <= sdr_din_d;
            sdr_wrl_q    <= sdr_wrl_d;
            sdr_wrh_q    <= sdr_wrh_d;
            wait_q       <= wait_d;
            done_q       <= done_d;
            err_q        <= err_d;
            bytes_q      <= bytes_d;
        end
    end

    assign ioctl_wait    = wait_q;
    assign sdr_addr      = sdr_addr_q;
    assign sdr_din       = sdr_din_q;
    assign sdr_wrl       = sdr_wrl_q;
    assign sdr_wrh       = sdr_wrh_q;
    assign sdr_req       = sdr_req_q;
    assign done          = done_q;
    assign err_overrun   = err_q;
    assign bytes_written = bytes_q;

endmodule
